// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared PS/2 definitions: receive FSM state encoding, frame
//                length and the scancode prefixes used by the keyboard path.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   localparam int         PS2_FRAME_BITS  = 11;
   localparam logic [7:0] PS2_BREAK_CODE  = 8'hF0;
   localparam logic [7:0] PS2_EXT_CODE    = 8'hE0;

   // Odd parity holds when data bits plus the parity bit contain an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic p);
      return ^{data, p};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_filter
//  Description : Two-flop synchroniser followed by a run-length filter. The
//                output follows the input only after LEN consecutive
//                synchronised samples disagree with it. Resets to 1 (idle).
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_filter #(
   parameter int LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   localparam int            CW      = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(LEN - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] run_cnt;
   logic          filt;

   // Bring the asynchronous pin into the clk domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   // Count consecutive disagreeing samples; flip the output on the LEN-th one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_cnt <= '0;
         filt    <= 1'b1;
      end else if (sync2 == filt) begin
         run_cnt <= '0;
      end else if (run_cnt == CNT_MAX) begin
         run_cnt <= '0;
         filt    <= sync2;
      end else begin
         run_cnt <= run_cnt + CW'(1);
      end
   end

   assign dout = filt;

endmodule
`default_nettype wire

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_receiver
//  Description : PS/2 device-to-host receiver. Filters the raw pins, detects
//                falling edges of the filtered clock, deserialises 11-bit
//                frames and reports a scancode or a parity/frame error.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scancode,
   output logic       newdata,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int            TW   = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TERM = TW'(TIMEOUT - 1);

   logic          clk_f;
   logic          data_f;
   logic          clk_f_d;
   logic          fall;
   logic          timeout_hit;

   ps2_state_t    state, state_nx;
   logic [2:0]    bitcnt, bitcnt_nx;
   logic [7:0]    shreg, shreg_nx;
   logic          par, par_nx;
   logic [TW-1:0] to_cnt, to_cnt_nx;

   logic          newdata_nx;
   logic          perr_nx;
   logic          ferr_nx;

   ps2_filter #(.LEN(FILTER_LEN)) u_clk_filter (
      .clk   (clk),
      .reset (reset),
      .din   (ps2_clk),
      .dout  (clk_f)
   );

   ps2_filter #(.LEN(FILTER_LEN)) u_data_filter (
      .clk   (clk),
      .reset (reset),
      .din   (ps2_data),
      .dout  (data_f)
   );

   // Delay the filtered clock by one cycle to find its falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) clk_f_d <= 1'b1;
      else       clk_f_d <= clk_f;
   end

   assign fall = clk_f_d & ~clk_f;

   // A fall in the terminal-count cycle wins, so the frame keeps going.
   assign timeout_hit = (state != ST_IDLE) && !fall && (to_cnt == TERM);

   // State register together with the frame datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         bitcnt <= 3'd0;
         shreg  <= 8'h00;
         par    <= 1'b0;
         to_cnt <= '0;
      end else begin
         state  <= state_nx;
         bitcnt <= bitcnt_nx;
         shreg  <= shreg_nx;
         par    <= par_nx;
         to_cnt <= to_cnt_nx;
      end
   end

   // Next-state logic: frame sequencing on each fall plus the inactivity timer.
   always_comb begin
      state_nx  = state;
      bitcnt_nx = bitcnt;
      shreg_nx  = shreg;
      par_nx    = par;
      to_cnt_nx = to_cnt;

      if (state == ST_IDLE || fall) begin
         to_cnt_nx = '0;
      end else if (timeout_hit) begin
         to_cnt_nx = '0;
         state_nx  = ST_IDLE;
         shreg_nx  = 8'h00;
      end else begin
         to_cnt_nx = to_cnt + TW'(1);
      end

      if (fall) begin
         case (state)
            ST_IDLE: begin
               if (!data_f) begin
                  state_nx  = ST_DATA;
                  bitcnt_nx = 3'd0;
               end
            end
            ST_DATA: begin
               shreg_nx = {data_f, shreg[7:1]};
               if (bitcnt == 3'd7) state_nx = ST_PARITY;
               else                bitcnt_nx = bitcnt + 3'd1;
            end
            ST_PARITY: begin
               par_nx   = data_f;
               state_nx = ST_STOP;
            end
            default: begin
               state_nx = ST_IDLE;
            end
         endcase
      end
   end

   // Output decode: choose at most one strobe for the frame being closed.
   always_comb begin
      newdata_nx = 1'b0;
      perr_nx    = 1'b0;
      ferr_nx    = 1'b0;
      if (timeout_hit) begin
         ferr_nx = 1'b1;
      end else if (fall && state == ST_STOP) begin
         if (!data_f)                         ferr_nx    = 1'b1;
         else if (!odd_parity_ok(shreg, par)) perr_nx    = 1'b1;
         else                                 newdata_nx = 1'b1;
      end
   end

   // Registered outputs; scancode only moves on a good frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scancode   <= 8'h00;
         newdata    <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         newdata    <= newdata_nx;
         parity_err <= perr_nx;
         frame_err  <= ferr_nx;
         if (newdata_nx) scancode <= shreg;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_receiver
//  Description : Self-checking bench for ps2_receiver. A PS/2 device model
//                drives frames; expected outcomes are queued and a monitor
//                compares them against the DUT strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_receiver;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 500;
   localparam int HALF       = 40;     // clk cycles per PS/2 clock phase
   localparam int K_NEW      = 0;
   localparam int K_PERR     = 1;
   localparam int K_FERR     = 2;

   typedef struct {
      int         kind;
      logic [7:0] sc;
   } exp_t;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       ps2_clk  = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] scancode;
   logic       newdata;
   logic       parity_err;
   logic       frame_err;

   exp_t       exp_q[$];
   int         checks        = 0;
   int         failures      = 0;
   int         cyc           = 0;
   int         last_ferr_cyc = -1;
   int         last_fall_cyc = 0;
   logic [7:0] model_sc      = 8'h00;

   ps2_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .scancode   (scancode),
      .newdata    (newdata),
      .parity_err (parity_err),
      .frame_err  (frame_err)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_exp(input int kind, input logic [7:0] sc);
      exp_t e;
      e.kind = kind;
      e.sc   = sc;
      exp_q.push_back(e);
   endtask

   // Monitor: every strobe consumes one expected outcome.
   always @(negedge clk) begin
      if (!reset && (newdata || parity_err || frame_err)) begin
         exp_t e;
         int   act_kind;
         if (frame_err) last_ferr_cyc = cyc;
         act_kind = newdata ? K_NEW : (parity_err ? K_PERR : K_FERR);
         check("single_strobe", 32'(newdata) + 32'(parity_err) + 32'(frame_err), 32'd1);
         check("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("strobe_kind", act_kind, e.kind);
            check("scancode", 32'(scancode), 32'(e.sc));
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Device model: data changes mid-high-phase, then the clock falls.
   task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
      for (int i = 0; i < nbits; i++) begin
         wait_cyc(HALF / 2);
         ps2_data = bits[i];
         if (glitch) begin
            wait_cyc(5);
            ps2_clk = 1'b0;
            wait_cyc(1);
            ps2_clk = 1'b1;
            wait_cyc(HALF / 2 - 6);
         end else begin
            wait_cyc(HALF / 2);
         end
         ps2_clk       = 1'b0;
         last_fall_cyc = cyc;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
      wait_cyc(HALF / 2);
      ps2_data = 1'b1;
      wait_cyc(HALF / 2);
   endtask

   // Whole frame; the expected outcome follows directly from the frame rules.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input bit glitch);
      logic        p;
      logic [10:0] bits;
      p    = ~(^b) ^ bad_par;
      bits = {~bad_stop, p, b, 1'b0};
      if (bad_stop)     push_exp(K_FERR, model_sc);
      else if (bad_par) push_exp(K_PERR, model_sc);
      else begin
         model_sc = b;
         push_exp(K_NEW, b);
      end
      send_bits(bits, 11, glitch);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         wait_cyc(1);
         n++;
      end
      wait_cyc(5);
      check(name, exp_q.size(), 0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_scancode"}, 32'(scancode), 32'd0);
      check({tag, "_newdata"}, 32'(newdata), 32'd0);
      check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
      check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
   endtask

   initial begin
      #1_800_000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int delta;
      int n;

      // Reset state
      wait_cyc(5);
      check_outputs_zero("reset");
      reset = 1'b0;
      wait_cyc(20);

      // Single good frame
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      drain("drain_single");

      // Break prefix then code, back to back
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      drain("drain_pair");

      // Inverted parity
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      drain("drain_parity");

      // Bad stop bit, then recovery
      send_frame(8'h29, 1'b0, 1'b1, 1'b0);
      send_frame(8'h29, 1'b0, 1'b0, 1'b0);
      drain("drain_stop");

      // Truncated frame aborted by the timeout
      push_exp(K_FERR, model_sc);
      last_ferr_cyc = -1;
      send_bits(11'b111_0110_0010, 5, 1'b0);
      n = 0;
      while (exp_q.size() != 0 && n < TIMEOUT + 200) begin
         wait_cyc(1);
         n++;
      end
      delta = last_ferr_cyc - last_fall_cyc;
      check("timeout_delay_in_window",
            32'(last_ferr_cyc >= 0 && delta >= TIMEOUT && delta <= TIMEOUT + 30), 32'd1);
      send_frame(8'h45, 1'b0, 1'b0, 1'b0);
      drain("drain_timeout");

      // Glitches on an idle line and inside frames
      for (int i = 0; i < 4; i++) begin
         ps2_clk = 1'b0;
         wait_cyc(1);
         ps2_clk = 1'b1;
         wait_cyc(30);
      end
      send_frame(8'h3B, 1'b0, 1'b0, 1'b1);
      send_frame(8'hE0, 1'b0, 1'b0, 1'b1);
      drain("drain_glitch");

      // Reset in the middle of a frame
      send_bits(11'b110_1010_1010, 4, 1'b0);
      ps2_clk = 1'b0;
      wait_cyc(5);
      reset = 1'b1;
      wait_cyc(3);
      check_outputs_zero("midreset");
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(30);
      reset    = 1'b0;
      model_sc = 8'h00;
      wait_cyc(20);
      send_frame(8'h77, 1'b0, 1'b0, 1'b0);
      drain("drain_midreset");

      // Randomised frames with occasional faults and glitches
      for (int i = 0; i < 24; i++) begin
         logic [7:0] b;
         int         r;
         b = 8'($urandom);
         r = $urandom_range(0, 9);
         send_frame(b, r == 0, r == 1, 1'($urandom_range(0, 1)));
         wait_cyc($urandom_range(0, 3 * HALF));
      end
      drain("drain_random");

      check("queue_empty_end", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
